// File: rtl/ctrl_pkg.sv
// Shared encodings for the RV64I multicycle control unit: FSM states, opcodes,
// datapath select codes and the branch funct3 values that are recognised.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_ALU_WB   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_LOAD_WB  = 4'd7,
        S_MEM_WR   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LUI      = 4'd12,
        S_HALT     = 4'd13,
        S_TRAP     = 4'd14
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_SUB    = 2'b01;
    localparam logic [1:0] ALU_RFUNCT = 2'b10;
    localparam logic [1:0] ALU_IFUNCT = 2'b11;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_RS1   = 2'b01;
    localparam logic [1:0] SRC_A_OLDPC = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;

    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;
    localparam logic [1:0] WB_IMM    = 2'b11;

    localparam logic [1:0] PC_ALU       = 2'b00;
    localparam logic [1:0] PC_ALUOUT    = 2'b01;
    localparam logic [1:0] PC_ALU_ALIGN = 2'b10;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_JALR = 3'b000;

    // States that own the shared memory port and are subject to the wait limit.
    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Opcode/funct3 dispatch table used by the DECODE state; unknown encodings
// raise illegal and point at TRAP.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    output state_t     dispatch,
    output logic       illegal
);

    always_comb begin
        dispatch = S_TRAP;
        illegal  = 1'b0;
        case (opcode)
            OP_R:             dispatch = S_EXEC_R;
            OP_I:             dispatch = S_EXEC_I;
            OP_LOAD, OP_STORE: dispatch = S_MEM_ADDR;
            OP_BRANCH:        dispatch = S_BRANCH;
            OP_JAL:           dispatch = S_JAL;
            OP_JALR: begin
                if (funct3 == F3_JALR) begin
                    dispatch = S_JALR;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_LUI:           dispatch = S_LUI;
            OP_SYSTEM:        dispatch = S_HALT;
            default:          illegal  = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RV64I sequencer: one state per datapath step, memory wait/timeout
// handling, retired-instruction counter and sticky halt/trap states.
module multicycle_control_unit
    import ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = 16,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic             alu_zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ir_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       mem_to_reg,
    output logic [1:0]       pc_src,
    output logic             halted,
    output logic             trap,
    output logic [CNT_W-1:0] instret,
    output logic [3:0]       state_dbg
);

    localparam int WAIT_W = $clog2(WAIT_LIMIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_LIMIT - 1);

    state_t             state_reg, state_next, dispatch;
    logic               illegal;
    logic [WAIT_W-1:0]  wait_cnt_reg, wait_cnt_next;
    logic [CNT_W-1:0]   instret_reg, instret_next;
    logic               retire, wait_expired, branch_taken;
    logic [2:0]         funct3;

    logic               pc_write_int, ir_write_int, mem_read_int, mem_write_int;
    logic               reg_write_int, halted_int, trap_int;
    logic [1:0]         alu_src_a_int, alu_src_b_int, alu_op_int, mem_to_reg_int, pc_src_int;

    logic               unused_instr_bits;
    assign unused_instr_bits = ^{instr[31:15], instr[11:7]};

    assign funct3 = instr[14:12];

    ctrl_decode u_decode (
        .opcode   (instr[6:0]),
        .funct3   (funct3),
        .dispatch (dispatch),
        .illegal  (illegal)
    );

    // Expiry fires on the last allowed wait cycle; mem_ready in that cycle still completes.
    assign wait_expired = is_mem_state(state_reg) && !mem_ready && (wait_cnt_reg == WAIT_LAST);
    assign branch_taken = ((funct3 == F3_BEQ) && alu_zero) || ((funct3 == F3_BNE) && !alu_zero);

    always_comb begin
        state_next     = state_reg;
        retire         = 1'b0;
        pc_write_int   = 1'b0;
        ir_write_int   = 1'b0;
        mem_read_int   = 1'b0;
        mem_write_int  = 1'b0;
        reg_write_int  = 1'b0;
        halted_int     = 1'b0;
        trap_int       = 1'b0;
        alu_src_a_int  = SRC_A_PC;
        alu_src_b_int  = SRC_B_RS2;
        alu_op_int     = ALU_ADD;
        mem_to_reg_int = WB_ALUOUT;
        pc_src_int     = PC_ALU;
        case (state_reg)
            S_FETCH: begin
                mem_read_int  = 1'b1;
                alu_src_b_int = SRC_B_FOUR;
                if (mem_ready) begin
                    ir_write_int = 1'b1;
                    pc_write_int = 1'b1;
                    state_next   = S_DECODE;
                end else if (wait_expired) begin
                    state_next = S_TRAP;
                end
            end
            S_DECODE: begin
                alu_src_a_int = SRC_A_OLDPC;
                alu_src_b_int = SRC_B_IMM;
                state_next    = illegal ? S_TRAP : dispatch;
                retire        = !illegal && (dispatch == S_HALT);
            end
            S_EXEC_R: begin
                alu_src_a_int = SRC_A_RS1;
                alu_op_int    = ALU_RFUNCT;
                state_next    = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a_int = SRC_A_RS1;
                alu_src_b_int = SRC_B_IMM;
                alu_op_int    = ALU_IFUNCT;
                state_next    = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write_int = 1'b1;
                state_next    = S_FETCH;
                retire        = 1'b1;
            end
            S_MEM_ADDR: begin
                alu_src_a_int = SRC_A_RS1;
                alu_src_b_int = SRC_B_IMM;
                // Opcode bit 5 separates store (0100011) from load (0000011).
                state_next    = instr[5] ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_read_int = 1'b1;
                if (mem_ready) begin
                    state_next = S_LOAD_WB;
                end else if (wait_expired) begin
                    state_next = S_TRAP;
                end
            end
            S_LOAD_WB: begin
                reg_write_int  = 1'b1;
                mem_to_reg_int = WB_MDR;
                state_next     = S_FETCH;
                retire         = 1'b1;
            end
            S_MEM_WR: begin
                mem_write_int = 1'b1;
                if (mem_ready) begin
                    state_next = S_FETCH;
                    retire     = 1'b1;
                end else if (wait_expired) begin
                    state_next = S_TRAP;
                end
            end
            S_BRANCH: begin
                alu_src_a_int = SRC_A_RS1;
                alu_op_int    = ALU_SUB;
                pc_src_int    = PC_ALUOUT;
                pc_write_int  = branch_taken;
                state_next    = S_FETCH;
                retire        = 1'b1;
            end
            S_JAL: begin
                reg_write_int  = 1'b1;
                mem_to_reg_int = WB_PC;
                pc_write_int   = 1'b1;
                pc_src_int     = PC_ALUOUT;
                state_next     = S_FETCH;
                retire         = 1'b1;
            end
            S_JALR: begin
                alu_src_a_int  = SRC_A_RS1;
                alu_src_b_int  = SRC_B_IMM;
                reg_write_int  = 1'b1;
                mem_to_reg_int = WB_PC;
                pc_write_int   = 1'b1;
                pc_src_int     = PC_ALU_ALIGN;
                state_next     = S_FETCH;
                retire         = 1'b1;
            end
            S_LUI: begin
                reg_write_int  = 1'b1;
                mem_to_reg_int = WB_IMM;
                state_next     = S_FETCH;
                retire         = 1'b1;
            end
            S_HALT:  halted_int = 1'b1;
            S_TRAP:  trap_int   = 1'b1;
            default: state_next = S_TRAP;
        endcase
    end

    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        if (state_next != state_reg) begin
            wait_cnt_next = '0;
        end else if (is_mem_state(state_reg) && !mem_ready) begin
            wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
        end
        instret_next = retire ? instret_reg + CNT_W'(1) : instret_reg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_FETCH;
            wait_cnt_reg <= '0;
            instret_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            instret_reg  <= instret_next;
        end
    end

    // Everything is forced quiet during reset so an aborted access never writes.
    assign pc_write   = pc_write_int  & ~reset;
    assign ir_write   = ir_write_int  & ~reset;
    assign mem_read   = mem_read_int  & ~reset;
    assign mem_write  = mem_write_int & ~reset;
    assign reg_write  = reg_write_int & ~reset;
    assign halted     = halted_int    & ~reset;
    assign trap       = trap_int      & ~reset;
    assign alu_src_a  = reset ? 2'b00 : alu_src_a_int;
    assign alu_src_b  = reset ? 2'b00 : alu_src_b_int;
    assign alu_op     = reset ? 2'b00 : alu_op_int;
    assign mem_to_reg = reset ? 2'b00 : mem_to_reg_int;
    assign pc_src     = reset ? 2'b00 : pc_src_int;
    assign instret    = reset ? '0 : instret_reg;
    assign state_dbg  = state_reg;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: directed scenarios plus random instruction streams with
// random memory latency, checked against a per-instruction-class cost model.
module tb_multicycle_control_unit;
    import ctrl_pkg::*;

    localparam int WAIT_LIMIT = 16;
    localparam int CNT_W      = 32;

    localparam int C_R = 0, C_I = 1, C_LOAD = 2, C_STORE = 3, C_BR = 4;
    localparam int C_JAL = 5, C_JALR = 6, C_LUI = 7, C_ILL = 8, C_EBREAK = 9;

    logic             clk = 1'b0;
    logic             reset;
    logic [31:0]      instr;
    logic             alu_zero;
    logic             mem_ready;
    logic             pc_write, ir_write, mem_read, mem_write, reg_write;
    logic [1:0]       alu_src_a, alu_src_b, alu_op, mem_to_reg, pc_src;
    logic             halted, trap;
    logic [CNT_W-1:0] instret;
    logic [3:0]       state_dbg;

    int total = 0;
    int passes = 0;
    int exp_instret = 0;

    always #5 clk = ~clk;

    multicycle_control_unit #(.WAIT_LIMIT(WAIT_LIMIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .instr(instr), .alu_zero(alu_zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .mem_to_reg(mem_to_reg), .pc_src(pc_src), .halted(halted), .trap(trap),
        .instret(instret), .state_dbg(state_dbg)
    );

    task automatic check(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    function automatic logic [31:0] make_instr(input int cls, input logic [2:0] f3);
        logic [31:0] w;
        w = $urandom;
        w[14:12] = f3;
        case (cls)
            C_R:     w[6:0] = 7'b0110011;
            C_I:     w[6:0] = 7'b0010011;
            C_LOAD:  w[6:0] = 7'b0000011;
            C_STORE: w[6:0] = 7'b0100011;
            C_BR:    w[6:0] = 7'b1100011;
            C_JAL:   w[6:0] = 7'b1101111;
            C_JALR:  begin w[6:0] = 7'b1100111; w[14:12] = 3'b000; end
            C_LUI:   w[6:0] = 7'b0110111;
            C_EBREAK: w = 32'h0010_0073;
            default: w[6:0] = 7'b1111111;
        endcase
        return w;
    endfunction

    // Runs one instruction from FETCH; fw/mw are wait cycles on the fetch / data access.
    task automatic run_instr(input string tag, input int cls, input logic [31:0] iw,
                             input int fw, input int mw, input logic z);
        int e_cyc, e_rd, e_wr, e_rw, e_pcw, e_wb, e_src, e_joint, e_state;
        int cyc, rd, wr, rw, pcw, irw, wb, src, joint, acc, age;
        logic prev_rd, prev_wr, taken, done;
        taken = ((iw[14:12] == 3'd0) && z) || ((iw[14:12] == 3'd1) && !z);
        e_rd = 1 + fw; e_wr = 0; e_rw = 1; e_pcw = 1; e_wb = -1; e_src = -1; e_joint = 0;
        e_state = S_FETCH;
        case (cls)
            C_R, C_I: begin e_cyc = 4; e_wb = 0; end
            C_LOAD:   begin e_cyc = 5 + mw; e_rd = 2 + fw + mw; e_wb = 1; end
            C_STORE:  begin e_cyc = 4 + mw; e_wr = 1 + mw; e_rw = 0; end
            C_BR:     begin e_cyc = 3; e_rw = 0; e_pcw = taken ? 2 : 1; if (taken) e_src = 1; end
            C_JAL:    begin e_cyc = 3; e_wb = 2; e_pcw = 2; e_src = 1; e_joint = 1; end
            C_JALR:   begin e_cyc = 3; e_wb = 2; e_pcw = 2; e_src = 2; e_joint = 1; end
            C_LUI:    begin e_cyc = 3; e_wb = 3; end
            C_EBREAK: begin e_cyc = 2; e_rw = 0; e_state = S_HALT; end
            default:  begin e_cyc = 2; e_rw = 0; e_state = S_TRAP; end
        endcase
        e_cyc += fw;
        if (cls != C_ILL) exp_instret++;

        instr = iw; alu_zero = z;
        cyc = 0; rd = 0; wr = 0; rw = 0; pcw = 0; irw = 0; wb = -1; src = -1; joint = 0;
        acc = 0; age = 0; prev_rd = 1'b0; prev_wr = 1'b0; done = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if ((mem_read && prev_rd) || (mem_write && prev_wr)) age++;
            else if (mem_read || mem_write) begin age = 0; acc++; end
            prev_rd = mem_read; prev_wr = mem_write;
            mem_ready = (mem_read || mem_write) && (age == ((acc == 1) ? fw : mw));
            #1;
            cyc++;
            if (mem_read) rd++;
            if (mem_write) wr++;
            if (ir_write) irw++;
            if (pc_write) pcw++;
            if (reg_write) begin rw++; wb = int'(mem_to_reg); if (pc_write) joint++; end
            if (pc_write && !ir_write) src = int'(pc_src);
            @(posedge clk); #1;
            if ((state_dbg == S_FETCH && irw > 0) || state_dbg == S_HALT || state_dbg == S_TRAP) begin
                done = 1'b1;
                break;
            end
        end
        mem_ready = 1'b0;
        check({tag, ".done"}, int'(done), 1);
        check({tag, ".cycles"}, cyc, e_cyc);
        check({tag, ".mem_read_cycles"}, rd, e_rd);
        check({tag, ".mem_write_cycles"}, wr, e_wr);
        check({tag, ".ir_write_cycles"}, irw, 1);
        check({tag, ".pc_write_cycles"}, pcw, e_pcw);
        check({tag, ".reg_write_cycles"}, rw, e_rw);
        check({tag, ".wb_sel"}, wb, e_wb);
        check({tag, ".late_pc_src"}, src, e_src);
        check({tag, ".wb_pc_same_cycle"}, joint, e_joint);
        check({tag, ".end_state"}, int'(state_dbg), e_state);
        check({tag, ".halted"}, int'(halted), int'(cls == C_EBREAK));
        check({tag, ".trap"}, int'(trap), int'(cls == C_ILL));
        check({tag, ".instret"}, int'(instret), exp_instret);
        $display("txn %s cls=%0d instr=%08h fw=%0d mw=%0d z=%0d cycles=%0d instret=%0d",
                 tag, cls, iw, fw, mw, z, cyc, instret);
    endtask

    // Ends at posedge+1 with reset low and the FSM in FETCH.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        exp_instret = 0;
        check("reset.state", int'(state_dbg), S_FETCH);
        check("reset.instret", int'(instret), 0);
    endtask

    // Absorbing states: no strobes regardless of memory activity.
    task automatic hold_check(input string tag, input int st, input int n);
        int busy;
        busy = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            mem_ready = 1'($urandom);
            alu_zero  = 1'($urandom);
            #1;
            if (mem_read || mem_write || reg_write || pc_write || ir_write || int'(state_dbg) != st) busy++;
        end
        check({tag, ".absorbing"}, busy, 0);
        check({tag, ".halted"}, int'(halted), int'(st == S_HALT));
        check({tag, ".trap"}, int'(trap), int'(st == S_TRAP));
        check({tag, ".instret"}, int'(instret), exp_instret);
        $display("txn %s hold %0d cycles state=%0d", tag, n, state_dbg);
    endtask

    initial begin
        int wc, rwc, cls, fw, mw;
        logic reached;

        // Reset for two edges, then addi x1,x0,5 with zero-wait memory.
        reset = 1'b1; instr = 32'h0050_0093; mem_ready = 1'b1; alu_zero = 1'b0;
        @(posedge clk); @(negedge clk); #1;
        check("rst.mem_read", int'(mem_read), 0);
        check("rst.alu_src_b", int'(alu_src_b), 0);
        check("rst.pc_write", int'(pc_write), 0);
        check("rst.instret", int'(instret), 0);
        check("rst.trap_halted", int'({trap, halted}), 0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk); #1;
        check("addi.c1.state", int'(state_dbg), S_FETCH);
        check("addi.c1.ir_pc_write", int'({ir_write, pc_write, mem_read}), 7);
        @(negedge clk); #1;
        check("addi.c2.state", int'(state_dbg), S_DECODE);
        @(negedge clk); #1;
        check("addi.c3.state", int'(state_dbg), S_EXEC_I);
        check("addi.c3.alu_op", int'(alu_op), 3);
        @(negedge clk); #1;
        check("addi.c4.state", int'(state_dbg), S_ALU_WB);
        check("addi.c4.reg_write", int'(reg_write), 1);
        @(posedge clk); #1;
        check("addi.instret", int'(instret), 1);
        $display("txn addi instret=%0d", instret);
        exp_instret = 1;
        mem_ready = 1'b0;

        run_instr("beq_taken", C_BR, 32'h0000_0063, 0, 0, 1'b1);
        run_instr("beq_not_taken", C_BR, 32'h0000_0063, 0, 0, 1'b0);
        run_instr("bne_taken", C_BR, 32'h0000_1063, 0, 0, 1'b0);
        run_instr("blt_ignored", C_BR, 32'h0000_4063, 1, 0, 1'b1);
        run_instr("load_wait3", C_LOAD, 32'h0000_A083, 0, 3, 1'b0);
        run_instr("load_wait_limit", C_LOAD, 32'h0000_A083, 0, WAIT_LIMIT - 1, 1'b0);
        run_instr("fetch_wait_limit", C_LUI, 32'h1234_50B7, WAIT_LIMIT - 1, 0, 1'b0);

        for (int k = 0; k < 30; k++) begin
            cls = int'($urandom_range(0, 7));
            fw  = int'($urandom_range(0, 3));
            mw  = int'($urandom_range(0, 5));
            run_instr($sformatf("rnd%0d", k), cls, make_instr(cls, 3'($urandom)), fw, mw, 1'($urandom));
        end

        // Store whose data access never completes.
        instr = 32'h0020_A023; wc = 0; rwc = 0; reached = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            mem_ready = mem_read;
            #1;
            if (mem_write) wc++;
            if (reg_write) rwc++;
            @(posedge clk); #1;
            if (state_dbg == S_TRAP) begin reached = 1'b1; break; end
        end
        check("store_timeout.reached", int'(reached), 1);
        check("store_timeout.mem_write_cycles", wc, WAIT_LIMIT);
        check("store_timeout.reg_write", rwc, 0);
        check("store_timeout.mem_write_dropped", int'(mem_write), 0);
        $display("txn store_timeout mem_write_cycles=%0d trap=%0d", wc, trap);
        hold_check("store_timeout", S_TRAP, 6);

        do_reset();
        run_instr("illegal_7f", C_ILL, 32'h0000_007F, 0, 0, 1'b0);
        hold_check("illegal_7f", S_TRAP, 5);
        do_reset();
        run_instr("lui_pre", C_LUI, 32'h0000_10B7, 0, 0, 1'b0);
        run_instr("ebreak", C_EBREAK, 32'h0010_0073, 2, 0, 1'b0);
        hold_check("ebreak", S_HALT, 5);

        // Reset landing in the middle of a store's data access.
        do_reset();
        instr = 32'h0020_A023; reached = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (state_dbg == S_MEM_WR) begin reached = 1'b1; break; end
            mem_ready = mem_read;
            @(posedge clk); #1;
        end
        check("rst_in_memwr.reached", int'(reached), 1);
        reset = 1'b1; mem_ready = 1'b1;
        #1;
        check("rst_in_memwr.mem_write", int'(mem_write), 0);
        @(posedge clk); #1 reset = 1'b0; mem_ready = 1'b0;
        exp_instret = 0;
        check("rst_in_memwr.state", int'(state_dbg), S_FETCH);
        check("rst_in_memwr.instret", int'(instret), 0);
        $display("txn rst_in_memwr state=%0d instret=%0d", state_dbg, instret);
        run_instr("jal_after_reset", C_JAL, 32'h0080_00EF, 0, 0, 1'b0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
